// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control bundle between the debug/start logic, the pc
// register / program memory and the pc_sequencer instruction-cycle controller.
// The sequencer connects through the slave modport; whoever drives the
// start/step/decoder/pc inputs uses the master modport.
interface pc_sequencer_if #(
    parameter int N_BUS_IN = 11,
    parameter int N_CNT    = 16
);
    logic                i_start;
    logic                i_step_mode;
    logic                i_step;
    logic                i_halt_op;
    logic [N_BUS_IN-1:0] i_pc;

    logic                o_WrPC;
    logic [N_BUS_IN-1:0] o_sum1;
    logic                o_fetch_en;
    logic                o_exec_en;
    logic                o_running;
    logic                o_halted;
    logic [N_CNT-1:0]    o_instr_count;

    modport master (
        output i_start, i_step_mode, i_step, i_halt_op, i_pc,
        input  o_WrPC, o_sum1, o_fetch_en, o_exec_en, o_running, o_halted,
               o_instr_count
    );

    modport slave (
        input  i_start, i_step_mode, i_step, i_halt_op, i_pc,
        output o_WrPC, o_sum1, o_fetch_en, o_exec_en, o_running, o_halted,
               o_instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-cycle controller for the program counter.
// Each instruction runs as FETCH then EXEC; supports free-run, single-step
// (rising edge of i_step) and a terminal HALT that only reset leaves.
// o_WrPC and o_sum1 are combinational so they settle before the pc
// register's falling-edge capture; every other output is decoded from state.
// Optional feature: define INSTR_COUNT_EN to build the saturating
// retired-instruction counter; otherwise o_instr_count is tied to zero.
module pc_sequencer #(
    parameter int N_BUS_IN = 11,
    parameter int N_CNT    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pc_sequencer_if.slave        ctl
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXEC      = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   step_q;
    logic   step_edge;
    logic   retire;

    logic   fetch_en;
    logic   exec_en;
    logic   running;
    logic   halted;

    // A step request is a low-to-high transition; holding i_step high
    // therefore produces a single step.
    assign step_edge = ctl.i_step & ~step_q;

    // An instruction retires in EXEC unless it is the HALT instruction,
    // in which case the PC is left pointing at it.
    assign retire = (state_q == S_EXEC) && !ctl.i_halt_op;

    // State register and step edge-detector history.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= ctl.i_step;
        end
    end

    // Next-state selection and Moore output decode.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        fetch_en = 1'b0;
        exec_en  = 1'b0;
        running  = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctl.i_start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                running  = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                exec_en = 1'b1;
                running = 1'b1;
                if (ctl.i_halt_op) begin
                    state_d = S_HALT;
                end else if (ctl.i_step_mode) begin
                    state_d = S_WAIT_STEP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WAIT_STEP: begin
                // Only a fresh step edge resumes; dropping i_step_mode here
                // does not restart free-run on its own.
                running = 1'b1;
                if (step_edge) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ctl.o_fetch_en = fetch_en;
    assign ctl.o_exec_en  = exec_en;
    assign ctl.o_running  = running;
    assign ctl.o_halted   = halted;
    assign ctl.o_WrPC     = retire;

    // Next PC wraps naturally at 2^N_BUS_IN; no overflow flag is raised.
    assign ctl.o_sum1 = ctl.i_pc + N_BUS_IN'(1);

`ifdef INSTR_COUNT_EN
    logic [N_CNT-1:0] count_q, count_d;

    // Saturating count of retired instructions.
    always_comb begin
        count_d = count_q;
        if (retire && (count_q != {N_CNT{1'b1}})) begin
            count_d = count_q + N_CNT'(1);
        end
    end

    // Counter register; cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ctl.o_instr_count = count_q;
`else
    assign ctl.o_instr_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed bench for pc_sequencer.
// A behavioural model tracks the instruction phase, the previous step level,
// the number of retired instructions and acts as the external pc register.
// A second instance with a 2-bit counter mirrors the same stimulus so that
// counter saturation is reachable in a few instructions.
module tb_pc_sequencer;

    localparam int N_BUS_IN = 11;
    localparam int N_CNT    = 16;
    localparam int N_CNT2   = 2;
    localparam int PC_MOD   = 1 << N_BUS_IN;
    localparam int CNT_MAX  = (1 << N_CNT) - 1;
    localparam int CNT2_MAX = (1 << N_CNT2) - 1;

    logic clk;
    logic rst;

    pc_sequencer_if #(.N_BUS_IN(N_BUS_IN), .N_CNT(N_CNT))  if1 ();
    pc_sequencer_if #(.N_BUS_IN(N_BUS_IN), .N_CNT(N_CNT2)) if2 ();

    assign if2.i_start     = if1.i_start;
    assign if2.i_step_mode = if1.i_step_mode;
    assign if2.i_step      = if1.i_step;
    assign if2.i_halt_op   = if1.i_halt_op;
    assign if2.i_pc        = if1.i_pc;

    pc_sequencer #(.N_BUS_IN(N_BUS_IN), .N_CNT(N_CNT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .ctl     (if1.slave)
    );

    pc_sequencer #(.N_BUS_IN(N_BUS_IN), .N_CNT(N_CNT2)) dut2 (
        .i_clk   (clk),
        .i_reset (rst),
        .ctl     (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum int {PH_IDLE, PH_FETCH, PH_EXEC, PH_PARKED, PH_STOPPED} phase_t;

    phase_t m_ph;
    logic   m_prev_step;
    int     m_retired;
    int     m_pc;

    int n_tests;
    int n_fail;
    int cyc;

    // Expected outputs: {WrPC, sum1, fetch, exec, running, halted, cnt16, cnt2}
    function automatic logic [33:0] exp_vec();
        logic                wr;
        logic [N_BUS_IN-1:0] s;
        logic [N_CNT-1:0]    c1;
        logic [N_CNT2-1:0]   c2;
        wr = (m_ph == PH_EXEC) && !if1.i_halt_op;
        s  = N_BUS_IN'((int'(if1.i_pc) + 1) % PC_MOD);
`ifdef INSTR_COUNT_EN
        c1 = N_CNT'((m_retired > CNT_MAX) ? CNT_MAX : m_retired);
        c2 = N_CNT2'((m_retired > CNT2_MAX) ? CNT2_MAX : m_retired);
`else
        c1 = '0;
        c2 = '0;
`endif
        return {wr, s, (m_ph == PH_FETCH), (m_ph == PH_EXEC),
                (m_ph == PH_FETCH || m_ph == PH_EXEC || m_ph == PH_PARKED),
                (m_ph == PH_STOPPED), c1, c2};
    endfunction

    function automatic logic [33:0] act_vec();
        return {if1.o_WrPC, if1.o_sum1, if1.o_fetch_en, if1.o_exec_en,
                if1.o_running, if1.o_halted, if1.o_instr_count, if2.o_instr_count};
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        if (rst) begin
            m_ph        = PH_IDLE;
            m_retired   = 0;
            m_prev_step = 1'b0;
        end else begin
            case (m_ph)
                PH_IDLE:  if (if1.i_start) m_ph = PH_FETCH;
                PH_FETCH: m_ph = PH_EXEC;
                PH_EXEC: begin
                    if (if1.i_halt_op) begin
                        m_ph = PH_STOPPED;
                    end else begin
                        m_retired++;
                        m_pc = (m_pc + 1) % PC_MOD;
                        m_ph = if1.i_step_mode ? PH_PARKED : PH_FETCH;
                    end
                end
                PH_PARKED: if (if1.i_step && !m_prev_step) m_ph = PH_FETCH;
                default: ;
            endcase
            m_prev_step = if1.i_step;
        end
    endtask

    // One clock: update model, let the DUT see the edge, re-drive the PC.
    task automatic tick();
        model_tick();
        @(posedge clk);
        @(negedge clk);
        if1.i_pc = N_BUS_IN'(m_pc);
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        if1.i_start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [33:0] a, e;
        rst = 1'b1;
        if1.i_start     = $urandom_range(0, 1);
        if1.i_step_mode = $urandom_range(0, 1);
        if1.i_step      = $urandom_range(0, 1);
        if1.i_halt_op   = $urandom_range(0, 1);
        tick();
        tick();
        rst = 1'b0;
        if1.i_start = 1'b0;
        #1;
        n_tests++;
        if ({if1.o_WrPC, if1.o_fetch_en, if1.o_exec_en, if1.o_running, if1.o_halted,
             if1.o_instr_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%b f=%b e=%b r=%b h=%b cnt=%0d, want all 0",
                     if1.o_WrPC, if1.o_fetch_en, if1.o_exec_en, if1.o_running,
                     if1.o_halted, if1.o_instr_count);
        end
        for (int i = 0; i < 4; i++) begin
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
        end
    endtask

    task automatic test_free_run_halt();
        logic [33:0] a, e;
        int execs;
        bit stopped;
        execs = 0;
        stopped = 0;
        m_pc = 0;
        if1.i_pc = '0;
        if1.i_step_mode = 1'b0;
        if1.i_step = 1'b0;
        if1.i_halt_op = 1'b0;
        apply_reset();
        if1.i_start = 1'b1;
        for (int i = 0; i < 40 && !stopped; i++) begin
            if1.i_halt_op = (m_ph == PH_EXEC) && (execs == 3);
            #1;
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL free_run cyc%0d: got %h want %h", cyc, a, e);
            end
            if (if1.i_halt_op) begin
                n_tests++;
                if (if1.o_WrPC !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_wrpc: got %b want 0", if1.o_WrPC);
                end
            end
            if (m_ph == PH_EXEC) execs++;
            tick();
            if1.i_start = 1'b0;
            stopped = (m_ph == PH_STOPPED);
        end
        n_tests++;
        if (!stopped) begin
            n_fail++;
            $display("FAIL halt_timeout: got no halt in 40 cycles, want halt");
        end
        #1;
        n_tests++;
        if ({if1.o_halted, if1.o_running} !== 2'b10) begin
            n_fail++;
            $display("FAIL halted_flag: got halted=%b running=%b want 1/0",
                     if1.o_halted, if1.o_running);
        end
        for (int i = 0; i < 10; i++) begin
            if1.i_start     = $urandom_range(0, 1);
            if1.i_step      = $urandom_range(0, 1);
            if1.i_step_mode = $urandom_range(0, 1);
            if1.i_halt_op   = $urandom_range(0, 1);
            #1;
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL halt_sticky cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
        end
`ifdef INSTR_COUNT_EN
        n_tests++;
        if (if1.o_instr_count !== 16'd3) begin
            n_fail++;
            $display("FAIL halt_count: got %0d want 3", if1.o_instr_count);
        end
`endif
    endtask

    task automatic test_single_step();
        logic [33:0] a, e;
        int fetches, execs;
        bit parked;
        fetches = 0;
        execs = 0;
        parked = 0;
        if1.i_step = 1'b0;
        if1.i_halt_op = 1'b0;
        if1.i_step_mode = 1'b1;
        apply_reset();
        if1.i_start = 1'b1;
        for (int i = 0; i < 10 && !parked; i++) begin
            #1;
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL step_enter cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
            if1.i_start = 1'b0;
            parked = (m_ph == PH_PARKED);
        end
        n_tests++;
        if (!parked) begin
            n_fail++;
            $display("FAIL step_park_timeout: got not parked, want parked");
        end
        // Clearing step mode while parked must not resume by itself.
        if1.i_step_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL step_parked cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
        end
        if1.i_step_mode = 1'b1;
        if1.i_step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            fetches += int'(if1.o_fetch_en);
            execs   += int'(if1.o_exec_en);
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL step_held cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
        end
        if1.i_step = 1'b0;
        n_tests++;
        if (fetches != 1 || execs != 1) begin
            n_fail++;
            $display("FAIL step_once: got fetch=%0d exec=%0d want 1/1", fetches, execs);
        end
    endtask

    task automatic test_pc_wrap();
        bit seen;
        seen = 0;
        if1.i_step = 1'b0;
        if1.i_halt_op = 1'b0;
        if1.i_step_mode = 1'b0;
        m_pc = PC_MOD - 2;
        apply_reset();
        if1.i_start = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (m_ph == PH_EXEC && m_pc == PC_MOD - 1) begin
                seen = 1;
                n_tests++;
                if (if1.o_sum1 !== 11'h000 || if1.o_WrPC !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pc_wrap: got sum1=%h wr=%b want 000/1",
                             if1.o_sum1, if1.o_WrPC);
                end
            end
            tick();
            if1.i_start = 1'b0;
        end
        #1;
        n_tests++;
        if (!seen || if1.o_fetch_en !== 1'b1 || if1.i_pc !== 11'h000) begin
            n_fail++;
            $display("FAIL pc_wrap_next: got seen=%0d fetch=%b pc=%h want 1/1/000",
                     seen, if1.o_fetch_en, if1.i_pc);
        end
    endtask

    task automatic test_reset_midrun();
        logic [33:0] a, e;
        if1.i_step_mode = 1'b0;
        if1.i_halt_op = 1'b0;
        apply_reset();
        if1.i_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if1.i_start = 1'b0;
        end
        n_tests++;
        if (m_ph != PH_EXEC) begin
            n_fail++;
            $display("FAIL midrun_phase: got phase %0d want EXEC", m_ph);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({if1.o_WrPC, if1.o_fetch_en, if1.o_exec_en, if1.o_running, if1.o_halted,
             if1.o_instr_count, if2.o_instr_count} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got wr=%b f=%b e=%b r=%b h=%b cnt=%0d want all 0",
                     if1.o_WrPC, if1.o_fetch_en, if1.o_exec_en, if1.o_running,
                     if1.o_halted, if1.o_instr_count);
        end
        for (int i = 0; i < 5; i++) begin
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL midrun_idle cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
            #1;
        end
    endtask

    task automatic test_saturation();
        logic [33:0] a, e;
        if1.i_step_mode = 1'b0;
        if1.i_halt_op = 1'b0;
        if1.i_step = 1'b0;
        apply_reset();
        if1.i_start = 1'b1;
        for (int i = 0; i < 30 && m_retired < 5; i++) begin
            #1;
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL saturate cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
            if1.i_start = 1'b0;
        end
        #1;
        n_tests++;
`ifdef INSTR_COUNT_EN
        if (if2.o_instr_count !== 2'd3 || if1.o_instr_count !== 16'd5) begin
            n_fail++;
            $display("FAIL saturate_final: got cnt2=%0d cnt16=%0d want 3/5",
                     if2.o_instr_count, if1.o_instr_count);
        end
`else
        if (if2.o_instr_count !== 2'd0 || if1.o_instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL count_disabled: got cnt2=%0d cnt16=%0d want 0/0",
                     if2.o_instr_count, if1.o_instr_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [33:0] a, e;
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            if1.i_start     = ($urandom_range(0, 3) == 0);
            if1.i_step_mode = $urandom_range(0, 1);
            if1.i_step      = ($urandom_range(0, 2) == 0);
            if1.i_halt_op   = ($urandom_range(0, 19) == 0);
            #1;
            a = act_vec(); e = exp_vec();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", cyc, a, e);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        m_ph        = PH_IDLE;
        m_prev_step = 1'b0;
        m_retired   = 0;
        m_pc        = 0;
        rst             = 1'b1;
        if1.i_start     = 1'b0;
        if1.i_step_mode = 1'b0;
        if1.i_step      = 1'b0;
        if1.i_halt_op   = 1'b0;
        if1.i_pc        = '0;
        @(negedge clk);
        test_reset();
        test_free_run_halt();
        test_single_step();
        test_pc_wrap();
        test_reset_midrun();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
